// File: rtl/hamming_decode.sv
// Hamming(21,16) decoder with single-error correction as a 2-stage elastic pipeline.
// Optional statistics counters are enabled by defining HAMMING_DEC_STATS_EN.
module hamming_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [20:0] code_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_out,
    output logic [4:0]  syndrome,
    output logic        err_corr,
    output logic        err_uncorr
`ifdef HAMMING_DEC_STATS_EN
   ,input  logic        cnt_clr,
    output logic [15:0] corr_cnt,
    output logic [15:0] uncorr_cnt
`endif
);

    localparam logic [4:0] LAST_POS = 5'd21;

    logic        s1_full;
    logic [20:0] s1_code;
    logic [4:0]  s1_syn;
    logic        s2_full;
    logic        s2_adv;
    logic        s1_adv;
    logic        accept;
    logic [20:0] fixed_code;
    logic [15:0] fixed_data;
    logic        corr_next;
    logic        uncorr_next;

    function automatic logic [4:0] calc_syndrome(input logic [20:0] c);
        logic [4:0] s;
        s = '0;
        for (int i = 0; i < 21; i++) begin
            if (c[i]) s = s ^ 5'(i + 1);
        end
        return s;
    endfunction

    // Data bits live at every index whose position is not a power of two.
    function automatic logic [15:0] extract_data(input logic [20:0] c);
        return {c[20:16], c[14:8], c[6:4], c[2]};
    endfunction

    // Ready depends only on pipeline occupancy and out_ready, never on in_valid.
    assign s2_adv    = !s2_full || out_ready;
    assign s1_adv    = s1_full && s2_adv;
    assign in_ready  = !s1_full || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_full;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fixed_code  = s1_code;
        corr_next   = 1'b0;
        uncorr_next = 1'b0;
        if (s1_syn != 5'd0 && s1_syn <= LAST_POS) begin
            fixed_code = s1_code ^ (21'd1 << (s1_syn - 5'd1));
            corr_next  = 1'b1;
        end else if (s1_syn > LAST_POS) begin
            uncorr_next = 1'b1;
        end
        fixed_data = extract_data(fixed_code);
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_full <= 1'b0;
            s1_code <= '0;
            s1_syn  <= '0;
        end else if (accept) begin
            s1_full <= 1'b1;
            s1_code <= code_in;
            s1_syn  <= calc_syndrome(code_in);
        end else if (s1_adv) begin
            s1_full <= 1'b0;
        end
    end

    // NOTE: output data registers are reset too, since they must read 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_full    <= 1'b0;
            data_out   <= '0;
            syndrome   <= '0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
        end else if (s2_adv) begin
            s2_full <= s1_full;
            if (s1_full) begin
                data_out   <= fixed_data;
                syndrome   <= s1_syn;
                err_corr   <= corr_next;
                err_uncorr <= uncorr_next;
            end
        end
    end

`ifdef HAMMING_DEC_STATS_EN
    logic deliver;
    assign deliver = out_valid && out_ready;

    // Clear takes priority over a same-cycle increment; counts stick at 0xFFFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (deliver) begin
            if (err_corr && corr_cnt != 16'hFFFF)     corr_cnt   <= corr_cnt + 16'd1;
            if (err_uncorr && uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hamming_decode.sv
// Testbench for hamming_decode: table vectors, random single-bit errors with a
// scoreboard, plus hand-written backpressure, latency and reset sequences.
module tb_hamming_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [20:0] code_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] data_out;
    logic [4:0]  syndrome;
    logic        err_corr;
    logic        err_uncorr;
`ifdef HAMMING_DEC_STATS_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
`endif

    hamming_decode dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .code_in    (code_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .syndrome   (syndrome),
        .err_corr   (err_corr),
        .err_uncorr (err_uncorr)
`ifdef HAMMING_DEC_STATS_EN
       ,.cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] code;
        logic [15:0] data;
        logic [4:0]  syn;
        logic        corr;
        logic        uncorr;
    } vec_t;

    localparam int DATA_IDX [16] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 16, 17, 18, 19, 20};

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_steps = 0;
    int   n_corr_model = 0;
    int   n_uncorr_model = 0;
    vec_t sb[$];
    vec_t cur;
    vec_t tab[8];
    bit   acc;
    bit   ov_s;
    bit   rand_bp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] encode(input logic [15:0] d);
        logic [20:0] c;
        logic        p;
        c = '0;
        for (int k = 0; k < 16; k++) c[DATA_IDX[k]] = d[k];
        for (int j = 0; j < 5; j++) begin
            p = 1'b0;
            for (int i = 0; i < 21; i++)
                if ((((i + 1) >> j) & 1) == 1) p = p ^ c[i];
            c[(1 << j) - 1] = p;
        end
        return c;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int   k;
        v.data   = 16'($urandom);
        v.code   = encode(v.data);
        v.uncorr = 1'b0;
        k = $urandom_range(0, 21);
        if (k == 21) begin
            v.syn  = 5'd0;
            v.corr = 1'b0;
        end else begin
            v.code[k] = ~v.code[k];
            v.syn     = 5'(k + 1);
            v.corr    = 1'b1;
        end
        return v;
    endfunction

    // One clock: sample handshakes at the falling edge, then move past the rising edge.
    task automatic step();
        vec_t e;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc  = in_valid && in_ready;
        ov_s = out_valid;
        if (acc) sb.push_back(cur);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("out_without_word", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("data_out",   {16'd0, data_out},   {16'd0, e.data});
                check("syndrome",   {27'd0, syndrome},   {27'd0, e.syn});
                check("err_corr",   {31'd0, err_corr},   {31'd0, e.corr});
                check("err_uncorr", {31'd0, err_uncorr}, {31'd0, e.uncorr});
`ifdef HAMMING_DEC_STATS_EN
                if (cnt_clr) begin
                    n_corr_model = 0;
                    n_uncorr_model = 0;
                end else begin
                    if (e.corr) n_corr_model++;
                    if (e.uncorr) n_uncorr_model++;
                end
`endif
            end
        end
        n_steps++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v);
        in_valid = 1'b1;
        code_in  = v.code;
        cur      = v;
        for (int i = 0; i < 200; i++) begin
            step();
            if (acc) break;
        end
        if (!acc) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() > 0; i++) step();
        check("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic check_stats(input string name);
`ifdef HAMMING_DEC_STATS_EN
        check({name, "_corr_cnt"},   {16'd0, corr_cnt},   n_corr_model);
        check({name, "_uncorr_cnt"}, {16'd0, uncorr_cnt}, n_uncorr_model);
`endif
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t a, b, c, x;
        int   s0;

        tab[0] = '{21'h1FFFFE, 16'hFFFF,  5'd0, 1'b0, 1'b0};
        tab[1] = '{21'h000010, 16'h0000,  5'd5, 1'b1, 1'b0};
        tab[2] = '{21'h008000, 16'h0000, 5'd16, 1'b1, 1'b0};
        tab[3] = '{21'h100200, 16'h8020, 5'd31, 1'b0, 1'b1};
        tab[4] = '{21'h000001, 16'h0000,  5'd1, 1'b1, 1'b0};
        tab[5] = '{21'h100000, 16'h0000, 5'd21, 1'b1, 1'b0};
        tab[6] = '{21'h008020, 16'h0004, 5'd22, 1'b0, 1'b1};
        tab[7] = '{21'h000000, 16'h0000,  5'd0, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",  {31'd0, out_valid},  32'd0);
        check("rst_data_out",   {16'd0, data_out},   32'd0);
        check("rst_syndrome",   {27'd0, syndrome},   32'd0);
        check("rst_err_corr",   {31'd0, err_corr},   32'd0);
        check("rst_err_uncorr", {31'd0, err_uncorr}, 32'd0);
        check_stats("rst");
        rst = 1'b0;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency: out_valid appears two cycles after the accepting cycle.
        out_ready = 1'b1;
        send(tab[0]);
        step();
        check("lat_cycle1_ov", {31'd0, ov_s}, 32'd0);
        step();
        check("lat_cycle2_ov", {31'd0, ov_s}, 32'd1);
        drain();

        // Table vectors, back-to-back.
        foreach (tab[i]) send(tab[i]);
        drain();
        check_stats("table");

        // Random single-bit errors under random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) send(rand_vec());
        drain();
        check_stats("random");

        // Throughput: one word per cycle with out_ready held high.
        out_ready = 1'b1;
        s0 = n_steps;
        for (int i = 0; i < 8; i++) send(rand_vec());
        check("throughput_cycles", n_steps - s0, 32'd8);
        drain();

        // Backpressure: third word stalls, output held, all three delivered in order.
        out_ready = 1'b0;
        a = rand_vec();
        b = rand_vec();
        c = rand_vec();
        send(a);
        send(b);
        in_valid = 1'b1;
        code_in  = c.code;
        cur      = c;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_not_accepted", {31'd0, acc}, 32'd0);
            check("bp_hold_valid",   {31'd0, out_valid}, 32'd1);
            check("bp_hold_data",    {16'd0, data_out}, {16'd0, a.data});
            check("bp_hold_syn",     {27'd0, syndrome}, {27'd0, a.syn});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc) break;
        end
        check("bp_third_accepted", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        drain();

`ifdef HAMMING_DEC_STATS_EN
        // Clear wins over a same-cycle increment.
        out_ready = 1'b0;
        send(tab[1]);
        step();
        step();
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_corr_cnt",   {16'd0, corr_cnt},   32'd0);
        check("clr_uncorr_cnt", {16'd0, uncorr_cnt}, 32'd0);
        drain();
`endif

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(tab[3]);
        send(tab[1]);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data_out",  {16'd0, data_out},  32'd0);
        sb.delete();
        n_corr_model   = 0;
        n_uncorr_model = 0;
        check_stats("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("flushed_no_output", {31'd0, ov_s}, 32'd0);
        end
        x = rand_vec();
        send(x);
        drain();
        check_stats("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
